// File: rtl/alu_share_arbiter_if.sv
// Request/response and shared-ALU bus for alu_share_arbiter.
// slave = arbiter side; master = clients plus the ALU instance.
interface alu_share_arbiter_if #(
    parameter int unsigned W = 4
);
    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic [3:0]   req0_f;
    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic [3:0]   req1_f;

    logic         rsp0_valid;
    logic         rsp0_ready;
    logic         rsp1_valid;
    logic         rsp1_ready;
    logic [W-1:0] rsp_y;
    logic         rsp_cout;
    logic         rsp_ov;

    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [3:0]   alu_f;
    logic [W-1:0] alu_y;
    logic         alu_cout;
    logic         alu_ov;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_f,
        input  req1_valid, req1_a, req1_b, req1_f,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_y, rsp_cout, rsp_ov,
        input  rsp0_ready, rsp1_ready,
        output alu_a, alu_b, alu_f,
        input  alu_y, alu_cout, alu_ov
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_f,
        output req1_valid, req1_a, req1_b, req1_f,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_y, rsp_cout, rsp_ov,
        output rsp0_ready, rsp1_ready,
        input  alu_a, alu_b, alu_f,
        output alu_y, alu_cout, alu_ov
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-client round-robin sequencer in front of one shared combinational ALU.
// Optional grant counters: define ALU_ARB_STATS_EN.
module alu_share_arbiter #(
    parameter int unsigned W = 4
) (
    input logic clk,
    input logic rst_n,
    alu_share_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0] grant_cnt0,
    output logic [15:0] grant_cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic         last_grant_q;
    logic         owner_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [3:0]   f_q;
    logic [W-1:0] y_q;
    logic         cout_q;
    logic         ov_q;

    logic         grant0;
    logic         grant1;
    logic         take0;
    logic         take1;

    // Readies are gated by rst_n so they read 0 while reset is held.
    always_comb begin
        grant0  = bus.req0_valid && (!bus.req1_valid || last_grant_q);
        grant1  = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
        take0   = rst_n && (state_q == IDLE) && grant0;
        take1   = rst_n && (state_q == IDLE) && grant1;
        state_d = state_q;
        case (state_q)
            IDLE:    if (take0 || take1) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (owner_q ? bus.rsp1_ready : bus.rsp0_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            f_q          <= '0;
            y_q          <= '0;
            cout_q       <= 1'b0;
            ov_q         <= 1'b0;
        end else begin
            state_q <= state_d;
            if (take0 || take1) begin
                owner_q      <= take1;
                last_grant_q <= take1;
                a_q          <= take1 ? bus.req1_a : bus.req0_a;
                b_q          <= take1 ? bus.req1_b : bus.req0_b;
                f_q          <= take1 ? bus.req1_f : bus.req0_f;
            end
            if (state_q == EXEC) begin
                y_q    <= bus.alu_y;
                cout_q <= bus.alu_cout;
                ov_q   <= bus.alu_ov;
            end
        end
    end

    assign bus.req0_ready = take0;
    assign bus.req1_ready = take1;
    assign bus.rsp0_valid = (state_q == RESP) && !owner_q;
    assign bus.rsp1_valid = (state_q == RESP) && owner_q;
    assign bus.rsp_y      = y_q;
    assign bus.rsp_cout   = cout_q;
    assign bus.rsp_ov     = ov_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_f      = f_q;

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (take0 && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
            if (take1 && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-requester round-robin arbiter and sequencer that shares one combinational ALU instance (4-bit operands A/B, 4-bit control F, outputs Y/Cout/OV) between independent clients. It accepts one operation at a time over a valid/ready handshake, latches operands, drives the shared ALU, captures its result one cycle later and returns it to the owning requester over a held response channel. It sits between the board-level front ends (switch/button or sequencer logic) and the ALU, which is instantiated beside it at the top level.

## Interface
- W, 4: operand/result width; matches ALU data width.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_valid, req1_valid  in  1  operation request from client 0/1.
- req0_ready, req1_ready  out  1  request accepted this cycle when high with valid.
- req0_a, req0_b, req1_a, req1_b  in  W  operands.
- req0_f, req1_f  in  4  ALU control code, passed through unmodified.
- rsp0_valid, rsp1_valid  out  1  result available for client 0/1.
- rsp0_ready, rsp1_ready  in  1  client consumes result.
- rsp_y  out  W  captured ALU result (shared by both response channels).
- rsp_cout, rsp_ov  out  1  captured ALU carry and overflow.
- alu_a, alu_b  out  W  to shared ALU A/B.
- alu_f  out  4  to shared ALU F.
- alu_y  in  W  from ALU Y.
- alu_cout, alu_ov  in  1  from ALU Cout/OV.
- grant_cnt0, grant_cnt1  out  16  accepted-request counters (only with ALU_ARB_STATS_EN).

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state IDLE.
- IDLE: arbitrate. Grant goes to sole valid requester; if both valid, to the one not granted last (last_grant register, reset value 1 so client 0 wins the first tie). reqN_ready = (state==IDLE) && grantN; combinational from valid is permitted. On handshake: latch a, b, f, owner id; update last_grant; go EXEC.
- EXEC (exactly one cycle): alu_a/alu_b/alu_f driven from latched registers; at end of cycle capture alu_y, alu_cout, alu_ov into rsp registers; go RESP.
- RESP: rspN_valid high only for owner; rsp_y/rsp_cout/rsp_ov held stable. On rspN_ready of owner: go IDLE. Ready from non-owner ignored.
- alu_a/alu_b/alu_f always driven from latched registers (stable between operations; reset 0).
- No requests accepted outside IDLE; both readies low in EXEC and RESP.
- Requester deasserting valid without handshake: no effect, no state change.
- F is opaque; no decoding, no width arithmetic performed in this block.

## Timing
- Cycle 0: handshake in IDLE. Cycle 1: EXEC, ALU sees new operands. Cycle 2: rsp valid high with result. Minimum 3 cycles per operation (response consumed in cycle 2 → IDLE in cycle 3, next accept cycle 3).
- Response held indefinitely until owner ready; no timeout.
- Reset values: req*_ready 0, rsp*_valid 0, rsp_y 0, rsp_cout 0, rsp_ov 0, alu_a/alu_b/alu_f 0, grant counters 0, last_grant 1.
- Reset asserted mid-operation: immediate return to IDLE, all outputs to reset values, in-flight result discarded, no response issued.
- Continuous contention: strict alternation 0,1,0,1…; neither client starved.

## Configuration
- ALU_ARB_STATS_EN defined: grant_cnt0/grant_cnt1 ports exist; each increments on its client's accepted handshake, saturates at 16'hFFFF, cleared only by reset.
- Not defined: ports and counters absent; arbitration and timing identical.

## Test plan
- Bench ALU stub: alu_y = (A+B) mod 16, alu_cout = carry, alu_ov = 0.
- Single request: req0 a=3,b=4,f=0 → ready same cycle, rsp0_valid two cycles later, rsp_y=7, cout=0; rsp1_valid stays 0.
- Carry/hold: req1 a=9,b=8 with rsp1_ready low 5 cycles → rsp_y=1, cout=1 held constant, req0_valid meanwhile gets no ready; release → IDLE next cycle.
- Contention: both valid continuously from reset, 4 operations → grant order 0,1,0,1; each response routed to correct client only.
- Back-to-back: single client with rsp_ready tied high → one accept every 3 cycles, alu_a/alu_b stable across EXEC.
- Reset in EXEC: assert rst_n low during EXEC → all outputs 0 asynchronously, no rsp_valid after release; next request served normally with last_grant=1 tie behaviour.
- Stats (ALU_ARB_STATS_EN): 3 client-0 and 2 client-1 operations → grant_cnt0=3, grant_cnt1=2; forced preload near saturation stays 16'hFFFF.
